alu_cmd_parser: RTL and testbench

- Upstream stage of the ALU. Receives a byte stream (e.g. from a UART RX) and assembles 6-byte command frames.
- Validates framing, checksum and opcode/type fields, then issues one command to the ALU: a parser_done pulse with src1, src2, dtype and operator held stable.
- Applies backpressure until the ALU reports alu_done, so exactly one command is in flight at a time.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_cmd_timeout.sv | 31 +++
 rtl/alu_cmd_parser.sv | 140 ++++++++++++++
 tb/tb_alu_cmd_parser.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: dtype flags, opcodes, parser error codes and frame geometry.
package alu_pkg;

  localparam logic [3:0] DT_I = 4'h8;
  localparam logic [3:0] DT_F = 4'h4;
  localparam logic [3:0] DT_U = 4'h2;
  localparam logic [3:0] DT_S = 4'h1;

  localparam logic [4:0] OP_SUM = 5'h10;
  localparam logic [4:0] OP_SUB = 5'h08;
  localparam logic [4:0] OP_MUL = 5'h04;
  localparam logic [4:0] OP_DIV = 5'h02;
  localparam logic [4:0] OP_RMD = 5'h01;
  localparam logic [4:0] OP_AND = 5'h11;
  localparam logic [4:0] OP_OR  = 5'h12;
  localparam logic [4:0] OP_XOR = 5'h14;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_CHECKSUM = 3'd1,
    ERR_FIELD    = 3'd2,
    ERR_BYTE_TO  = 3'd3,
    ERR_ALU_TO   = 3'd4
  } err_code_e;

  localparam int unsigned FRAME_LEN = 6;

  // Reserved opcode bits must be clear as well as the opcode being known.
  function automatic logic is_legal_op(input logic [7:0] opb);
    return (opb[7:5] == 3'b000) &&
           (opb[4:0] inside {OP_SUM, OP_SUB, OP_MUL, OP_DIV, OP_RMD, OP_AND, OP_OR, OP_XOR});
  endfunction

endpackage

// File: rtl/alu_cmd_timeout.sv
// Loadable saturating down-counter; expired is high once the loaded budget is used up.
module alu_cmd_timeout #(
  parameter int unsigned LIMIT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= W'(LIMIT);
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/alu_cmd_parser.sv
// Byte-stream command framer for the ALU: SOF, OPB, TYB, S1, S2, CS -> one command in flight.
module alu_cmd_parser
  import alu_pkg::*;
#(
  parameter logic [7:0]  SOF          = 8'hA5,
  parameter int unsigned BYTE_TIMEOUT = 1000,
  parameter int unsigned ALU_TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       alu_done,
  output logic       parser_done,
  output logic [7:0] src1,
  output logic [7:0] src2,
  output logic [3:0] dtype,
  output logic [4:0] operator,
  output logic       err_valid,
  output logic [2:0] err_code
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_OP, ST_TY, ST_S1, ST_S2, ST_CS, ST_ISSUE, ST_WAIT
  } state_e;

  state_e      state;
  state_e      frame_next;
  logic [31:0] hdr;
  logic        in_frame;
  logic        accept;
  logic        byte_exp;
  logic        alu_exp;
  logic [7:0]  csum;
  logic        field_ok;

  assign in_frame    = (state inside {ST_OP, ST_TY, ST_S1, ST_S2, ST_CS});
  assign rx_ready    = (state == ST_IDLE) || in_frame;
  assign accept      = rx_valid && rx_ready;
  assign parser_done = (state == ST_ISSUE);

  // hdr shifts in OPB..S2, so at the checksum byte it holds {OPB, TYB, S1, S2}.
  assign csum     = hdr[31:24] ^ hdr[23:16] ^ hdr[15:8] ^ hdr[7:0];
  assign field_ok = is_legal_op(hdr[31:24]) && (hdr[23:20] == 4'h0) && (hdr[19:16] != 4'h0);

  always_comb begin
    frame_next = ST_IDLE;
    unique case (state)
      ST_OP:   frame_next = ST_TY;
      ST_TY:   frame_next = ST_S1;
      ST_S1:   frame_next = ST_S2;
      ST_S2:   frame_next = ST_CS;
      default: frame_next = ST_IDLE;
    endcase
  end

  alu_cmd_timeout #(.LIMIT(BYTE_TIMEOUT)) u_byte_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .clr     (state == ST_IDLE),
    .en      (in_frame && !accept),
    .expired (byte_exp)
  );

  alu_cmd_timeout #(.LIMIT(ALU_TIMEOUT)) u_alu_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (parser_done),
    .clr     (state == ST_IDLE),
    .en      ((state == ST_WAIT) && !alu_done),
    .expired (alu_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hdr       <= '0;
      src1      <= '0;
      src2      <= '0;
      dtype     <= '0;
      operator  <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
    end else begin
      err_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept && (rx_data == SOF)) state <= ST_OP;
        end
        ST_OP, ST_TY, ST_S1, ST_S2: begin
          if (accept) begin
            hdr   <= {hdr[23:0], rx_data};
            state <= frame_next;
          end else if (byte_exp) begin
            err_valid <= 1'b1;
            err_code  <= ERR_BYTE_TO;
            state     <= ST_IDLE;
          end
        end
        ST_CS: begin
          if (accept) begin
            if (csum != rx_data) begin
              err_valid <= 1'b1;
              err_code  <= ERR_CHECKSUM;
              state     <= ST_IDLE;
            end else if (!field_ok) begin
              err_valid <= 1'b1;
              err_code  <= ERR_FIELD;
              state     <= ST_IDLE;
            end else begin
              operator <= hdr[28:24];
              dtype    <= hdr[19:16];
              src1     <= hdr[15:8];
              src2     <= hdr[7:0];
              state    <= ST_ISSUE;
            end
          end else if (byte_exp) begin
            err_valid <= 1'b1;
            err_code  <= ERR_BYTE_TO;
            state     <= ST_IDLE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (alu_done) begin
            state <= ST_IDLE;
          end else if (alu_exp) begin
            err_valid <= 1'b1;
            err_code  <= ERR_ALU_TO;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Directed and randomized frames against a frame-level reference of the command parser.
module tb_alu_cmd_parser;

  localparam int unsigned BT = 1000;
  localparam int unsigned AT = 4096;

  typedef logic [7:0] frame_t [6];

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       alu_done;
  logic       parser_done;
  logic [7:0] src1;
  logic [7:0] src2;
  logic [3:0] dtype;
  logic [4:0] operator;
  logic       err_valid;
  logic [2:0] err_code;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_src1;
  logic [7:0] exp_src2;
  logic [3:0] exp_dtype;
  logic [4:0] exp_op;

  logic [7:0] legal_ops [8] = '{8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h11, 8'h12, 8'h14};

  always #5 clk = ~clk;

  alu_cmd_parser #(
    .SOF          (8'hA5),
    .BYTE_TIMEOUT (BT),
    .ALU_TIMEOUT  (AT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .alu_done    (alu_done),
    .parser_done (parser_done),
    .src1        (src1),
    .src2        (src2),
    .dtype       (dtype),
    .operator    (operator),
    .err_valid   (err_valid),
    .err_code    (err_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame-level rules: checksum first, then opcode / reserved bits / nonzero dtype.
  function automatic int unsigned ref_err(input frame_t f);
    logic legal;
    if ((f[1] ^ f[2] ^ f[3] ^ f[4]) != f[5]) return 1;
    legal = 1'b0;
    foreach (legal_ops[i]) if (f[1] == legal_ops[i]) legal = 1'b1;
    if (!legal || (f[2] > 8'h0F) || (f[2] == 8'h00)) return 2;
    return 0;
  endfunction

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input frame_t f, input int unsigned max_gap);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(max_gap, 0)) tick();
      send(f[i]);
    end
  endtask

  // Called one step after the checksum byte edge; alu_delay < 0 means the ALU never answers.
  task automatic check_outcome(input frame_t f, input int alu_delay, input bit hold_rx);
    int unsigned e;
    e = ref_err(f);
    if (e == 0) begin
      exp_op    = f[1][4:0];
      exp_dtype = f[2][3:0];
      exp_src1  = f[3];
      exp_src2  = f[4];
      chk("issue_done", parser_done, 1);
      chk("issue_no_err", err_valid, 0);
      chk("issue_fields", {src1, src2, dtype, operator}, {exp_src1, exp_src2, exp_dtype, exp_op});
      chk("issue_ready", rx_ready, 0);
      if (hold_rx) begin
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
      end
      tick();
      chk("wait_ready", rx_ready, 0);
      chk("done_pulse", parser_done, 0);
      if (alu_delay < 0) begin
        repeat (AT) tick();
        chk("alu_limit_hold", err_valid, 0);
        chk("alu_limit_ready", rx_ready, 0);
        tick();
        chk("alu_to_valid", err_valid, 1);
        chk("alu_to_code", err_code, 4);
        chk("alu_to_ready", rx_ready, 1);
        tick();
        chk("alu_to_pulse", err_valid, 0);
      end else begin
        repeat (alu_delay) begin
          tick();
          chk("wait_hold_ready", rx_ready, 0);
        end
        alu_done = 1'b1;
        rx_valid = 1'b0;
        tick();
        alu_done = 1'b0;
        chk("idle_ready", rx_ready, 1);
        chk("idle_no_err", err_valid, 0);
        chk("idle_no_done", parser_done, 0);
      end
    end else begin
      chk("err_valid", err_valid, 1);
      chk("err_code", err_code, e);
      chk("err_no_done", parser_done, 0);
      chk("err_fields_held", {src1, src2, dtype, operator}, {exp_src1, exp_src2, exp_dtype, exp_op});
      chk("err_ready", rx_ready, 1);
      tick();
      chk("err_pulse", err_valid, 0);
    end
  endtask

  initial begin
    #10_000_000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t f;
    logic [7:0] b;

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    alu_done = 1'b0;
    repeat (3) tick();
    chk("rst_ready", rx_ready, 1);
    chk("rst_done", parser_done, 0);
    chk("rst_err", {err_valid, err_code}, 0);
    chk("rst_fields", {src1, src2, dtype, operator}, 0);
    rst = 1'b0;
    exp_src1 = 0; exp_src2 = 0; exp_dtype = 0; exp_op = 0;
    tick();

    f = '{8'hA5, 8'h12, 8'h08, 8'h3C, 8'h0F, 8'h29};
    send_frame(f, 0);
    check_outcome(f, 0, 0);

    f = '{8'hA5, 8'h12, 8'h08, 8'h3C, 8'h0F, 8'h28};
    send_frame(f, 0);
    check_outcome(f, 0, 0);

    f = '{8'hA5, 8'h13, 8'h08, 8'h01, 8'h01, 8'h1B};
    send_frame(f, 0);
    check_outcome(f, 0, 0);

    f = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h01, 8'h10};
    send_frame(f, 0);
    check_outcome(f, 0, 0);

    // Byte timeout: BT idle cycles are tolerated, one more raises the error.
    send(8'hA5);
    send(8'h10);
    repeat (BT) tick();
    chk("bt_limit_hold", err_valid, 0);
    chk("bt_limit_ready", rx_ready, 1);
    tick();
    chk("bt_valid", err_valid, 1);
    chk("bt_code", err_code, 3);
    chk("bt_fields_held", {src1, src2, dtype, operator}, {exp_src1, exp_src2, exp_dtype, exp_op});
    tick();
    chk("bt_pulse", err_valid, 0);

    // Byte arriving in the limit cycle wins.
    f = '{8'hA5, 8'h10, 8'h09, 8'h05, 8'h03, 8'h1F};
    send(f[0]); send(f[1]); send(f[2]);
    repeat (BT) tick();
    send(f[3]); send(f[4]); send(f[5]);
    check_outcome(f, 0, 0);

    // Noise in IDLE, then a frame whose WAIT sees rx_valid held high.
    send(8'h00); send(8'hFF); send(8'h5A);
    f = '{8'hA5, 8'h11, 8'h02, 8'hF0, 8'h0F, 8'hEC};
    send_frame(f, 0);
    check_outcome(f, 3, 1);

    f = '{8'hA5, 8'h01, 8'h01, 8'h07, 8'h02, 8'h05};
    send_frame(f, 0);
    check_outcome(f, -1, 0);

    f = '{8'hA5, 8'h04, 8'h04, 8'h81, 8'h7E, 8'hFF};
    send_frame(f, 0);
    check_outcome(f, AT, 0);

    // Reset in the middle of a frame.
    send(8'hA5); send(8'h14); send(8'h04);
    rst = 1'b1;
    tick();
    chk("midrst_ready", rx_ready, 1);
    chk("midrst_pulses", {parser_done, err_valid}, 0);
    chk("midrst_outs", {src1, src2, dtype, operator, err_code}, 0);
    rst = 1'b0;
    exp_src1 = 0; exp_src2 = 0; exp_dtype = 0; exp_op = 0;
    send(8'h05); send(8'h03); send(8'h16);
    repeat (3) begin
      tick();
      chk("postrst_quiet", {parser_done, err_valid}, 0);
    end
    chk("postrst_outs", {src1, src2, dtype, operator}, 0);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(2, 0)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send(b);
      end
      f[0] = 8'hA5;
      f[1] = ($urandom_range(3, 0) == 0) ? 8'($urandom) : legal_ops[$urandom_range(7, 0)];
      f[2] = ($urandom_range(3, 0) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
      f[3] = 8'($urandom);
      f[4] = 8'($urandom);
      f[5] = f[1] ^ f[2] ^ f[3] ^ f[4];
      if ($urandom_range(5, 0) == 0) f[5] = f[5] ^ 8'($urandom_range(255, 1));
      send_frame(f, 2);
      check_outcome(f, int'($urandom_range(5, 0)), bit'($urandom_range(1, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
